mdio_master: RTL and testbench

- IEEE 802.3 Clause 22 MDIO management master: drives MDC/MDIO into the ASIC's MDIO register slave (PAD22_MDC/PAD23_MDIO) so the bench or a host-side FPGA can access the regfile.
- Accepts one read/write command at a time over a valid/ready handshake, serialises the frame, and returns read data on a one-cycle response strobe.
- Generates MDC from the system clock with a programmable divider.

---
 rtl/mdio_master.sv | 173 +++++++++++++++++
 tb/tb_mdio_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO management master.
// Accepts one read/write command per valid/ready handshake, serialises the
// frame on MDC/MDIO and returns read data on a one-cycle response strobe.
// Optional build macro MDIO_PRE_SUPPRESS_EN adds cfg_pre_sup, which skips
// the 32-bit preamble for the accepted command when set.
module mdio_master #(
   parameter int unsigned DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phyad,
   input  logic [4:0]  cmd_regad,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
`ifdef MDIO_PRE_SUPPRESS_EN
   ,
   input  logic        cfg_pre_sup
`endif
);

   localparam int unsigned BIT_CYC = 2 * DIV;
   localparam int unsigned CW      = $clog2(BIT_CYC);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_DONE
   } state_t;

   state_t        state;
   state_t        nxt_state;
   logic [CW-1:0] cnt;
   logic [4:0]    fcnt;
   logic [4:0]    nxt_fcnt;
   logic [31:0]   sh;
   logic [31:0]   fw;
   logic [15:0]   rd_sh;
   logic          is_wr;
   logic          ta_err;
   logic          nxt_oe;
   logic          bit_end;
   logic          pre_skip;

`ifdef MDIO_PRE_SUPPRESS_EN
   assign pre_skip = cfg_pre_sup;
`else
   assign pre_skip = 1'b0;
`endif

   assign bit_end = (cnt == CW'(BIT_CYC - 1));

   // Post-preamble frame word: ST, OP, PHYAD, REGAD, TA, DATA (reads release TA/DATA)
   always_comb begin
      fw = {2'b01,
            cmd_write ? 2'b01 : 2'b10,
            cmd_phyad,
            cmd_regad,
            cmd_write ? 2'b10 : 2'b11,
            cmd_write ? cmd_wdata : 16'hFFFF};
   end

   // Field sequencing: following field and its bit count minus one
   always_comb begin
      nxt_state = S_IDLE;
      nxt_fcnt  = 5'd0;
      case (state)
         S_PRE:   begin nxt_state = S_ST;   nxt_fcnt = 5'd1;  end
         S_ST:    begin nxt_state = S_OP;   nxt_fcnt = 5'd1;  end
         S_OP:    begin nxt_state = S_PHY;  nxt_fcnt = 5'd4;  end
         S_PHY:   begin nxt_state = S_REG;  nxt_fcnt = 5'd4;  end
         S_REG:   begin nxt_state = S_TA;   nxt_fcnt = 5'd1;  end
         S_TA:    begin nxt_state = S_DATA; nxt_fcnt = 5'd15; end
         S_DATA:  begin nxt_state = S_DONE; nxt_fcnt = 5'd0;  end
         default: begin nxt_state = S_IDLE; nxt_fcnt = 5'd0;  end
      endcase
      nxt_oe = is_wr || !((nxt_state == S_TA) || (nxt_state == S_DATA));
   end

   // Frame FSM, bit timer, MDC generation, pad drive and read capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         fcnt      <= 5'd0;
         sh        <= 32'd0;
         rd_sh     <= 16'd0;
         is_wr     <= 1'b0;
         ta_err    <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 16'd0;
         rsp_err   <= 1'b0;
         mdc       <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               mdc <= 1'b0;
               cnt <= '0;
               if (cmd_valid) begin
                  is_wr     <= cmd_write;
                  ta_err    <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  mdio_oe   <= 1'b1;
                  if (pre_skip) begin
                     state  <= S_ST;
                     fcnt   <= 5'd1;
                     mdio_o <= fw[31];
                     sh     <= {fw[30:0], 1'b1};
                  end else begin
                     state  <= S_PRE;
                     fcnt   <= 5'd31;
                     mdio_o <= 1'b1;
                     sh     <= fw;
                  end
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               if (cnt == CW'(DIV)) begin
                  if (state == S_DATA) rd_sh <= {rd_sh[14:0], mdio_i};
                  if ((state == S_TA) && (fcnt == 5'd0)) ta_err <= mdio_i;
               end
               if (bit_end) begin
                  cnt <= '0;
                  mdc <= 1'b0;
                  if (fcnt != 5'd0) begin
                     fcnt <= fcnt - 5'd1;
                     if (state != S_PRE) begin
                        mdio_o <= sh[31];
                        sh     <= {sh[30:0], 1'b1};
                     end
                  end else begin
                     state <= nxt_state;
                     fcnt  <= nxt_fcnt;
                     if (nxt_state == S_DONE) begin
                        mdio_o    <= 1'b1;
                        mdio_oe   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_wr ? 16'd0 : rd_sh;
                        rsp_err   <= !is_wr && ta_err;
                     end else begin
                        mdio_o  <= sh[31];
                        sh      <= {sh[30:0], 1'b1};
                        mdio_oe <= nxt_oe;
                     end
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  mdc <= (cnt >= CW'(DIV - 1));
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: randomized self-checking bench for mdio_master with a
// frame-level reference model and a behavioural MDIO slave.
module tb_mdio_master;

   localparam int unsigned DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_phyad;
   logic [4:0]  cmd_regad;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        mdc;
   logic        mdio_o;
   logic        mdio_oe;
   logic        mdio_i;
`ifdef MDIO_PRE_SUPPRESS_EN
   logic        cfg_pre_sup;
`endif

   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   mdio_master #(.DIV(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_phyad (cmd_phyad),
      .cmd_regad (cmd_regad),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mdc       (mdc),
      .mdio_o    (mdio_o),
      .mdio_oe   (mdio_oe),
      .mdio_i    (mdio_i)
`ifdef MDIO_PRE_SUPPRESS_EN
      ,
      .cfg_pre_sup (cfg_pre_sup)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full 64-bit frame as it should appear on the wire (preamble first)
   function automatic logic [63:0] model_frame(input logic w, input logic [4:0] phy,
                                               input logic [4:0] rg, input logic [15:0] wd);
      return {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), phy, rg,
              (w ? 2'b10 : 2'b11), (w ? wd : 16'hFFFF)};
   endfunction

   // Slave response for post-preamble bit rel: smode 0 absent, 1 good, 2 bad TA
   function automatic logic slave_bit(input int rel, input logic w, input int smode,
                                      input logic [15:0] sd);
      if (w || smode == 0) return 1'b1;
      if (rel == 15) return (smode == 2);
      if (rel >= 16 && rel <= 31) return sd[31 - rel];
      return 1'b1;
   endfunction

   task automatic run_cmd(input logic w, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, input logic pre_sup, input int smode,
                          input logic [15:0] sd, input logic hold, input int abort_at,
                          output int unsigned t_acc, output int unsigned t_rsp);
      logic [63:0] got_o, got_oe, exp_f, exp_oe, mask;
      logic [15:0] exp_rd;
      logic        exp_err, prev_mdc, done;
      int          nrise, nbits, prelen;
      cmd_write = w;
      cmd_phyad = phy;
      cmd_regad = rg;
      cmd_wdata = wd;
`ifdef MDIO_PRE_SUPPRESS_EN
      cfg_pre_sup = pre_sup;
`endif
      cmd_valid = 1'b1;
      t_acc = 0;
      t_rsp = 0;
      done  = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (cmd_ready) begin
            t_acc = cyc;
            done  = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      check("accept", 64'(done), 64'd1);
      if (!done) begin
         cmd_valid = 1'b0;
         return;
      end
      prelen   = pre_sup ? 0 : 32;
      nbits    = pre_sup ? 32 : 64;
      got_o    = '0;
      got_oe   = '0;
      nrise    = 0;
      prev_mdc = 1'b0;
      done     = 1'b0;
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         if (mdc && !prev_mdc) begin
            got_o  = {got_o[62:0], mdio_o};
            got_oe = {got_oe[62:0], mdio_oe};
            nrise++;
         end
         if (!mdc && prev_mdc) mdio_i = slave_bit(nrise - prelen, w, smode, sd);
         prev_mdc = mdc;
         if (abort_at >= 0 && nrise == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            check("abort_mdc", 64'(mdc), 64'd0);
            check("abort_oe", 64'(mdio_oe), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_rsp", 64'(rsp_valid), 64'd0);
            check("abort_ready", 64'(cmd_ready), 64'd1);
            rst    = 1'b0;
            mdio_i = 1'b1;
            return;
         end
         if (rsp_valid) begin
            t_rsp = cyc;
            done  = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end
      check("rsp_seen", 64'(done), 64'd1);
      if (!done) return;
      exp_f   = model_frame(w, phy, rg, wd);
      exp_oe  = w ? '1 : ~64'h3FFFF;
      mask    = pre_sup ? 64'hFFFF_FFFF : '1;
      exp_rd  = w ? 16'd0 : ((smode == 0) ? 16'hFFFF : sd);
      exp_err = !w && (smode != 1);
      check("nbits", 64'(nrise), 64'(nbits));
      check("frame", got_o & exp_oe & mask, exp_f & exp_oe & mask);
      check("oe", got_oe & mask, exp_oe & mask);
      check("latency", 64'(t_rsp - t_acc), 64'(1 + (pre_sup ? 64 : 128) * DIV));
      check("rdata", 64'(rsp_rdata), 64'(exp_rd));
      check("err", 64'(rsp_err), 64'(exp_err));
      check("mdc_done", 64'(mdc), 64'd0);
      @(posedge clk); #1;
      check("ready_after", 64'(cmd_ready), 64'd1);
      check("mdc_gap", 64'(mdc), 64'd0);
      check("rsp_pulse", 64'(rsp_valid), 64'd0);
      check("rdata_hold", 64'(rsp_rdata), 64'(exp_rd));
      mdio_i = 1'b1;
   endtask

   initial begin
      int unsigned ta, tr, ta2, tr2;
      logic        rw;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_phyad = 5'd0;
      cmd_regad = 5'd0;
      cmd_wdata = 16'd0;
      mdio_i    = 1'b1;
`ifdef MDIO_PRE_SUPPRESS_EN
      cfg_pre_sup = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_rsp", 64'(rsp_valid), 64'd0);
      check("rst_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_err", 64'(rsp_err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mdc", 64'(mdc), 64'd0);
      check("rst_mdio_o", 64'(mdio_o), 64'd1);
      check("rst_oe", 64'(mdio_oe), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed frames
      run_cmd(1'b1, 5'h01, 5'h05, 16'h1234, 1'b0, 0, 16'h0000, 1'b0, -1, ta, tr);
      run_cmd(1'b0, 5'h01, 5'h02, 16'h0000, 1'b0, 1, 16'hA5C3, 1'b0, -1, ta, tr);
      run_cmd(1'b0, 5'h03, 5'h04, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, -1, ta, tr);

      // Queued commands with cmd_valid held high
      run_cmd(1'b1, 5'h07, 5'h08, 16'hBEEF, 1'b0, 0, 16'h0000, 1'b1, -1, ta, tr);
      run_cmd(1'b0, 5'h09, 5'h0A, 16'h0000, 1'b0, 1, 16'h5A5A, 1'b0, -1, ta2, tr2);
      check("queued_accept", 64'(ta2), 64'(tr + 1));

      // Reset in the PHY field, then a normal read
      run_cmd(1'b1, 5'h02, 5'h03, 16'hCAFE, 1'b0, 0, 16'h0000, 1'b0, 38, ta, tr);
      @(posedge clk); #1;
      run_cmd(1'b0, 5'h11, 5'h12, 16'h0000, 1'b0, 1, 16'h0F0F, 1'b0, -1, ta, tr);

      // Randomized commands and slave behaviours
      for (int k = 0; k < 6; k++) begin
         rw = 1'($urandom_range(0, 1));
         run_cmd(rw, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0,
                 int'($urandom_range(0, 2)), 16'($urandom), 1'b0, -1, ta, tr);
      end

`ifdef MDIO_PRE_SUPPRESS_EN
      run_cmd(1'b1, 5'h01, 5'h05, 16'h1234, 1'b1, 0, 16'h0000, 1'b0, -1, ta, tr);
      run_cmd(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 1, 16'($urandom),
              1'b0, -1, ta, tr);
      run_cmd(1'b1, 5'h04, 5'h06, 16'h8001, 1'b0, 0, 16'h0000, 1'b0, -1, ta, tr);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
